multdiv_ctrl: RTL
=================

# multdiv_ctrl

Sequencer that shares one iterative multiply/divide unit with the 5-stage pipeline. It detects a mul/div instruction sitting in DX, freezes the front of the pipeline, issues a single start pulse with latched operands, and waits for the unit's ready flag. On completion it hands the result, the exception flag and the destination register to the XM latch input for one cycle. It sits beside the ALU in the execute stage, between the DX latch and the XM latch.

## Interface

- TIMEOUT, 40: maximum WAIT cycles before forced completion (watchdog build only).
- CNT_W, 6: counter width; must satisfy 2^CNT_W > TIMEOUT.

- clock  in  1  master clock, rising edge.
- reset  in  1  synchronous, active-high; returns the block to IDLE.
- dx_is_mult  in  1  DX holds R-type instruction with ALU op 00110.
- dx_is_div  in  1  DX holds R-type instruction with ALU op 00111.
- dx_rd  in  5  DX instruction bits [26:22].
- dx_a, dx_b  in  32  bypassed operands A and B from DX.
- flush  in  1  squash of DX (taken branch/jump); aborts any operation in flight.
- md_ctrl_mult, md_ctrl_div  out  1  one-cycle start pulses to the unit.
- md_a, md_b  out  32  latched operands, stable from START to the end of the operation.
- md_result  in  32  unit result.
- md_exception  in  1  unit exception (div by zero, mult overflow); valid with md_ready.
- md_ready  in  1  unit result valid.
- stall  out  1  freeze PC, FD and DX; insert a nop into XM.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse; result/exception/rd are valid for XM.
- result  out  32  captured result.
- exception  out  1  captured exception (unit exception or timeout).
- rd  out  5  captured destination register.

## Operation

- States: IDLE, START, WAIT, DONE (2-bit encoding).
- IDLE: if dx_is_mult or dx_is_div, and flush is 0:
  - latch dx_a, dx_b, dx_rd and the op; if both requests are set, mult wins;
  - assert stall combinationally in the same cycle;
  - go to START.
- START:
  - pulse md_ctrl_mult or md_ctrl_div (the latched op only);
  - clear the counter; stall=1; go to WAIT.
- WAIT:
  - stall=1; counter increments each cycle;
  - md_ready=1: capture md_result and md_exception; go to DONE;
  - md_ready is ignored in any state other than WAIT.
- DONE:
  - done=1, stall=0; go to IDLE;
  - the instruction leaves DX this cycle, and the XM mux selects result/exception/rd over the ALU output.
- After DONE, IDLE sees the next DX instruction; the completed instruction is never reissued.
- flush in START/WAIT/DONE: go to IDLE next edge; no done pulse; captured outputs unchanged. A late md_ready is ignored.
- flush in IDLE blocks a new start.
- result, exception and rd hold their values until the next capture.

## Timing

- Reset values:
  - state = IDLE;
  - stall, busy, done, md_ctrl_mult, md_ctrl_div, exception = 0;
  - result, md_a, md_b = 0;
  - rd = 0.
- Reset mid-operation: IDLE on the next edge; no done pulse.
- Minimum latency (request seen at T0, md_ready at T2):
  - T0: stall=1;
  - T1: START pulse;
  - T2: WAIT;
  - T3: done=1.
  - This gives 3 stall cycles.
- General case: done = 1 cycle after the WAIT cycle in which md_ready is sampled high.
- Counter saturates at TIMEOUT; there is no wrap-around.

## Configuration

- MULTDIV_TIMEOUT_EN defined:
  - if the counter reaches TIMEOUT-1 in WAIT without md_ready, go to DONE with result=0 and exception=1;
  - md_ready in that same cycle takes priority.
- MULTDIV_TIMEOUT_EN undefined:
  - WAIT is unbounded; the counter is removed;
  - exception comes only from md_exception.

## Test plan

- mult with dx_a=6, dx_b=7, rd=5; md_ready at WAIT cycle 1 with md_result=42 → md_ctrl_mult pulses once; stall high for 3 cycles; done with result=42, rd=5, exception=0.
- div with dx_a=9, dx_b=0; unit returns md_exception=1 after 33 cycles → done with exception=1; stall deasserts exactly in the DONE cycle.
- Two back-to-back mults (rd=1, then rd=2) → two separate start pulses and two done pulses with the matching rd values; the first instruction is not reissued.
- flush asserted in WAIT cycle 4, then md_ready → no done; IDLE next cycle; previous result and rd are held.
- reset asserted in WAIT → all outputs at their reset values on the next edge; a following md_ready is ignored.
- With MULTDIV_TIMEOUT_EN and TIMEOUT=40: md_ready never asserted → done at WAIT cycle 40 with result=0 and exception=1.

Source files
------------

// File: rtl/multdiv_ctrl.sv
// rtl/multdiv_ctrl.sv - mul/div sequencer between DX and XM; watchdog build via MULTDIV_TIMEOUT_EN
module multdiv_ctrl
`ifdef MULTDIV_TIMEOUT_EN
  #(
    parameter int unsigned TIMEOUT = 40,
    parameter int unsigned CNT_W   = 6
  )
`endif
  (
  input  logic        clock,
  input  logic        reset,
  input  logic        dx_is_mult,
  input  logic        dx_is_div,
  input  logic [4:0]  dx_rd,
  input  logic [31:0] dx_a,
  input  logic [31:0] dx_b,
  input  logic        flush,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        exception,
  output logic [4:0]  rd
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        op_mult_q, op_mult_d;
  logic [4:0]  op_rd_q, op_rd_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic [4:0]  rd_q, rd_d;
  logic        accept;

`ifdef MULTDIV_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // A squashed DX instruction must never start the unit
  assign accept = (dx_is_mult | dx_is_div) & ~flush;

  // Next-state, operand latch and result capture
  always_comb begin
    state_d   = state_q;
    op_mult_d = op_mult_q;
    op_rd_d   = op_rd_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    exc_d     = exc_q;
    rd_d      = rd_q;
`ifdef MULTDIV_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_mult_d = dx_is_mult;  // mult wins when both are set
          op_rd_d   = dx_rd;
          a_d       = dx_a;
          b_d       = dx_b;
          state_d   = S_START;
        end
      end
      S_START: begin
`ifdef MULTDIV_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = flush ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
`ifdef MULTDIV_TIMEOUT_EN
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
`endif
        if (flush) begin
          state_d = S_IDLE;
        end else if (md_ready) begin
          result_d = md_result;
          exc_d    = md_exception;
          rd_d     = op_rd_q;
          state_d  = S_DONE;
        end
`ifdef MULTDIV_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          result_d = '0;
          exc_d    = 1'b1;
          rd_d     = op_rd_q;
          state_d  = S_DONE;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and data registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_mult_q <= 1'b0;
      op_rd_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      exc_q     <= 1'b0;
      rd_q      <= '0;
`ifdef MULTDIV_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_mult_q <= op_mult_d;
      op_rd_q   <= op_rd_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      exc_q     <= exc_d;
      rd_q      <= rd_d;
`ifdef MULTDIV_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // Stall rises in the same cycle the request is seen so the front end freezes at once
  assign stall = ~reset & (((state_q == S_IDLE) & accept) |
                           (state_q == S_START) | (state_q == S_WAIT));
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE) & ~flush & ~reset;
  assign md_ctrl_mult = (state_q == S_START) & op_mult_q;
  assign md_ctrl_div  = (state_q == S_START) & ~op_mult_q;
  assign md_a         = a_q;
  assign md_b         = b_q;
  assign result       = result_q;
  assign exception    = exc_q;
  assign rd           = rd_q;

endmodule
